// File: rtl/yc_noc_pkg.sv
// Shared NoC link definitions for the credit-based transmitter and its
// matching receiver.
//   yc_link_state_e : link control FSM states
//   credit_w(n)     : width of a counter holding 0..n credits
package yc_noc_pkg;

  typedef enum logic [1:0] {
    LINK_IDLE   = 2'd0,
    LINK_ACTIVE = 2'd1,
    LINK_DRAIN  = 2'd2
  } yc_link_state_e;

  function automatic int credit_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/yc_credit_counter.sv
// Saturating credit counter. Resets full (MAX) because the far-end buffer
// is empty after a joint reset.
//   clk, rst_n   : clock, async active-low reset
//   i_inc        : one credit returned this cycle
//   i_dec        : one credit consumed this cycle (never issued at zero)
//   o_count      : current credit count
//   o_zero       : count == 0
//   o_full       : count == MAX
//   o_ovf_pulse  : return while already full with no consume (count held)
module yc_credit_counter
  import yc_noc_pkg::*;
#(
  parameter  int MAX = 4,
  localparam int CW  = credit_w(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_zero,
  output logic          o_full,
  output logic          o_ovf_pulse
);

  logic [CW-1:0] r_count;

  assign o_count     = r_count;
  assign o_zero      = (r_count == '0);
  assign o_full      = (r_count == CW'(MAX));
  assign o_ovf_pulse = i_inc && !i_dec && o_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CW'(MAX);
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/yc_credit_tx.sv
// Transmit end of a credit-based NoC link. Flits accepted on a valid/ready
// port are forwarded onto a registered link while a far-end slot credit is
// held. link_en controls ACTIVE/DRAIN/IDLE so the link can be quiesced.
//   clk, rst_n      : clock, async active-low reset
//   i_link_en       : 1 = run, 0 = drain outstanding credits then idle
//   i_s_valid/data  : upstream flit
//   o_s_ready       : upstream accept (from registered state only)
//   o_link_valid    : registered one-cycle pulse per flit sent
//   o_link_data     : registered flit data, holds last value
//   i_credit_ret    : one credit returned per high cycle
//   o_credits       : current credit count
//   o_idle          : FSM in IDLE
//   o_err_ovf       : sticky, credit returned while count already full
module yc_credit_tx
  import yc_noc_pkg::*;
#(
  parameter  int W       = 32,
  parameter  int CREDITS = 4,
  localparam int CW      = credit_w(CREDITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_link_en,
  input  logic          i_s_valid,
  input  logic [W-1:0]  i_s_data,
  output logic          o_s_ready,
  output logic          o_link_valid,
  output logic [W-1:0]  o_link_data,
  input  logic          i_credit_ret,
  output logic [CW-1:0] o_credits,
  output logic          o_idle,
  output logic          o_err_ovf
);

  yc_link_state_e r_state, w_state_nxt;
  logic           w_send;
  logic           w_zero;
  logic           w_full;
  logic           w_ovf_pulse;
  logic           w_full_nxt;
  logic           r_link_valid;
  logic [W-1:0]   r_link_data;
  logic           r_err_ovf;

  yc_credit_counter #(.MAX(CREDITS)) u_credit_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (i_credit_ret),
    .i_dec       (w_send),
    .o_count     (o_credits),
    .o_zero      (w_zero),
    .o_full      (w_full),
    .o_ovf_pulse (w_ovf_pulse)
  );

  assign o_s_ready = (r_state == LINK_ACTIVE) && !w_zero;
  assign o_idle    = (r_state == LINK_IDLE);
  assign w_send    = i_s_valid && o_s_ready;

  // Post-update fullness: the count will equal CREDITS after this edge.
  assign w_full_nxt = w_send ? (w_full && i_credit_ret)
                             : (w_full || (i_credit_ret && (o_credits == CW'(CREDITS - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LINK_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Draining ends only once every outstanding flit has been credited back,
  // so the far-end buffer is provably empty when the link reads idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LINK_IDLE:   if (i_link_en) w_state_nxt = LINK_ACTIVE;
      LINK_ACTIVE: if (!i_link_en) w_state_nxt = LINK_DRAIN;
      LINK_DRAIN: begin
        if (w_full_nxt) w_state_nxt = LINK_IDLE;
        else if (i_link_en) w_state_nxt = LINK_ACTIVE;
      end
      default:     w_state_nxt = LINK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_link_valid <= w_send;
      if (w_send) r_link_data <= i_s_data;
      if (w_ovf_pulse) r_err_ovf <= 1'b1;
    end
  end

  assign o_link_valid = r_link_valid;
  assign o_link_data  = r_link_data;
  assign o_err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_yc_credit_tx.sv
module tb_yc_credit_tx;

  localparam int W       = 32;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  logic          clk;
  logic          rst_n;
  logic          link_en;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic          link_valid;
  logic [W-1:0]  link_data;
  logic          credit_ret;
  logic [CW-1:0] credits;
  logic          idle;
  logic          err_ovf;

  int n_vec = 0;
  int n_err = 0;

  yc_credit_tx #(.W(W), .CREDITS(CREDITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_link_en    (link_en),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .o_s_ready    (s_ready),
    .o_link_valid (link_valid),
    .o_link_data  (link_data),
    .i_credit_ret (credit_ret),
    .o_credits    (credits),
    .o_idle       (idle),
    .o_err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    link_en    = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    credit_ret = 1'b0;
    #12;
    chk("rst_credits", 32'(credits), 4);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_link_valid", 32'(link_valid), 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_err_ovf", 32'(err_ovf), 0);
    rst_n = 1'b1;
    tick();

    // idle ignores link traffic until enabled
    link_en = 1'b1;
    tick();
    chk("active_s_ready", 32'(s_ready), 1);
    chk("active_idle", 32'(idle), 0);

    // burst until credits run out
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hA0 + 32'(i);
      tick();
      chk("burst_valid", 32'(link_valid), 1);
      chk("burst_data", link_data, 32'hA0 + 32'(i));
      chk("burst_credits", 32'(credits), 32'(3 - i));
    end
    s_data = 32'hA4;
    tick();
    chk("stall_valid", 32'(link_valid), 0);
    chk("stall_s_ready", 32'(s_ready), 0);
    chk("stall_credits", 32'(credits), 0);
    chk("stall_data_hold", link_data, 32'hA3);
    tick();
    chk("stall2_valid", 32'(link_valid), 0);

    // single credit return from zero
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("ret1_credits", 32'(credits), 1);
    chk("ret1_s_ready", 32'(s_ready), 1);
    chk("ret1_valid", 32'(link_valid), 0);
    tick();
    chk("ret1_send_valid", 32'(link_valid), 1);
    chk("ret1_send_data", link_data, 32'hA4);
    chk("ret1_send_credits", 32'(credits), 0);
    chk("ret1_send_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;

    // bring credits to 2, then send and return together
    credit_ret = 1'b1;
    tick();
    tick();
    chk("pre_b2b_credits", 32'(credits), 2);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 32'hB0 + 32'(i);
      tick();
      chk("b2b_valid", 32'(link_valid), 1);
      chk("b2b_data", link_data, 32'hB0 + 32'(i));
      chk("b2b_credits", 32'(credits), 2);
    end
    s_valid    = 1'b0;
    credit_ret = 1'b0;
    tick();
    chk("b2b_end_valid", 32'(link_valid), 0);
    chk("b2b_err_ovf", 32'(err_ovf), 0);

    // refill to full without overflow
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    chk("refill_credits", 32'(credits), 4);
    chk("refill_err_ovf", 32'(err_ovf), 0);

    // three sends, link_en drops alongside the third
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hC0 + 32'(i);
      if (i == 2) link_en = 1'b0;
      tick();
      chk("drain_send_credits", 32'(credits), 32'(3 - i));
    end
    s_valid = 1'b0;
    chk("drain_last_valid", 32'(link_valid), 1);
    chk("drain_last_data", link_data, 32'hC2);
    chk("drain_s_ready", 32'(s_ready), 0);
    chk("drain_idle", 32'(idle), 0);
    credit_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_ret_credits", 32'(credits), 32'(2 + i));
      chk("drain_ret_idle", 32'(idle), (i == 2) ? 32'd1 : 32'd0);
    end
    credit_ret = 1'b0;
    chk("idle_s_ready", 32'(s_ready), 0);

    // re-enable, send one, drain, then re-enable mid-drain
    link_en = 1'b1;
    tick();
    chk("reen_s_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = 32'hD0;
    tick();
    s_valid = 1'b0;
    chk("reen_credits", 32'(credits), 3);
    link_en = 1'b0;
    tick();
    chk("middrain_s_ready", 32'(s_ready), 0);
    chk("middrain_idle", 32'(idle), 0);
    link_en = 1'b1;
    tick();
    chk("middrain_back_s_ready", 32'(s_ready), 1);
    chk("middrain_back_idle", 32'(idle), 0);
    chk("middrain_back_credits", 32'(credits), 3);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("restore_credits", 32'(credits), 4);
    chk("restore_err_ovf", 32'(err_ovf), 0);

    // overflow: return while full
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("ovf_credits", 32'(credits), 4);
    chk("ovf_err", 32'(err_ovf), 1);
    s_valid = 1'b1;
    s_data  = 32'hE0;
    tick();
    s_valid = 1'b0;
    chk("ovf_traffic_valid", 32'(link_valid), 1);
    chk("ovf_traffic_credits", 32'(credits), 3);
    chk("ovf_sticky1", 32'(err_ovf), 1);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("ovf_sticky_credits", 32'(credits), 4);
    chk("ovf_sticky2", 32'(err_ovf), 1);

    // async reset between edges with a flit on the link
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hF0 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("prerst_valid", 32'(link_valid), 1);
    chk("prerst_credits", 32'(credits), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(link_valid), 0);
    chk("arst_credits", 32'(credits), 4);
    chk("arst_idle", 32'(idle), 1);
    chk("arst_err_ovf", 32'(err_ovf), 0);
    chk("arst_link_data", link_data, 0);
    chk("arst_s_ready", 32'(s_ready), 0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
